operand_fetch: RTL and testbench

Operand fetch sequencer for the RV32I datapath. It accepts a two-source-register request (rs1, rs2) and reads both operands through the register file's single combinational read port, one per cycle. It then holds the pair on a valid/ready response interface until the execute stage consumes it. It sits between decode and execute, drives the register file's `readnum`, and snoops the register file's write port to keep captured operands coherent.

---
 rtl/operand_fetch_if.sv | 29 ++
 rtl/operand_fetch.sv | 104 ++++++++++
 tb/tb_operand_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Request / register-file / write-back snoop / response bundle for operand_fetch.
// The master modport is the surrounding pipeline; the slave modport is the sequencer.
interface operand_fetch_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_rs1;
  logic [4:0]      req_rs2;
  logic [4:0]      rf_readnum;
  logic [XLEN-1:0] rf_data_out;
  logic            wb_write;
  logic [4:0]      wb_writenum;
  logic [XLEN-1:0] wb_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rs1_val;
  logic [XLEN-1:0] rsp_rs2_val;

  modport master (
    output req_valid, req_rs1, req_rs2, rf_data_out,
    output wb_write, wb_writenum, wb_data, rsp_ready,
    input  req_ready, rf_readnum, rsp_valid, rsp_rs1_val, rsp_rs2_val
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, rf_data_out,
    input  wb_write, wb_writenum, wb_data, rsp_ready,
    output req_ready, rf_readnum, rsp_valid, rsp_rs1_val, rsp_rs2_val
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads rs1 then rs2 through one register-file port and holds the pair.
// Write-back forwarding is compiled in with `define OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus_io
);

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ1, READ2, RESP} state_e;

  state_e          state_q, state_d;
  logic [4:0]      rs1Idx_q, rs1Idx_d;
  logic [4:0]      rs2Idx_q, rs2Idx_d;
  logic [XLEN-1:0] rs1Val_q, rs1Val_d;
  logic [XLEN-1:0] rs2Val_q, rs2Val_d;

  logic active;
  logic clearHit;
  logic byp1Hit;
  logic byp2Hit;

  // A write to x0 clears the whole register file, so every operand we hold goes to zero.
  always_comb begin
    active   = (state_q != IDLE);
    clearHit = active && bus_io.wb_write && (bus_io.wb_writenum == 5'd0);
    byp1Hit  = BypassEn && active && bus_io.wb_write && (bus_io.wb_writenum != 5'd0)
               && (bus_io.wb_writenum == rs1Idx_q);
    byp2Hit  = BypassEn && active && bus_io.wb_write && (bus_io.wb_writenum != 5'd0)
               && (bus_io.wb_writenum == rs2Idx_q);
  end

  always_comb begin
    state_d           = state_q;
    rs1Idx_d          = rs1Idx_q;
    rs2Idx_d          = rs2Idx_q;
    rs1Val_d          = rs1Val_q;
    rs2Val_d          = rs2Val_q;
    bus_io.req_ready  = 1'b0;
    bus_io.rsp_valid  = 1'b0;
    bus_io.rf_readnum = 5'd0;

    if (byp1Hit) rs1Val_d = bus_io.wb_data;
    if (byp2Hit) rs2Val_d = bus_io.wb_data;

    case (state_q)
      IDLE: begin
        bus_io.req_ready = 1'b1;
        if (bus_io.req_valid) begin
          rs1Idx_d = bus_io.req_rs1;
          rs2Idx_d = bus_io.req_rs2;
          state_d  = READ1;
        end
      end
      READ1: begin
        bus_io.rf_readnum = rs1Idx_q;
        if (!byp1Hit) rs1Val_d = (rs1Idx_q == 5'd0) ? '0 : bus_io.rf_data_out;
        state_d = READ2;
      end
      READ2: begin
        bus_io.rf_readnum = rs2Idx_q;
        if (!byp2Hit) rs2Val_d = (rs2Idx_q == 5'd0) ? '0 : bus_io.rf_data_out;
        state_d = RESP;
      end
      RESP: begin
        bus_io.rsp_valid = 1'b1;
        if (bus_io.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clearHit) begin
      rs1Val_d = '0;
      rs2Val_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rs1Idx_q <= 5'd0;
      rs2Idx_q <= 5'd0;
      rs1Val_q <= '0;
      rs2Val_q <= '0;
    end else begin
      state_q  <= state_d;
      rs1Idx_q <= rs1Idx_d;
      rs2Idx_q <= rs2Idx_d;
      rs1Val_q <= rs1Val_d;
      rs2Val_q <= rs2Val_d;
    end
  end

  assign bus_io.rsp_rs1_val = rs1Val_q;
  assign bus_io.rsp_rs2_val = rs2Val_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file on the snooped write port.
// Expected values follow the OPERAND_FETCH_BYPASS_EN setting of the build.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BypassOn = 1'b1;
`else
  localparam bit BypassOn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vectorCount;
  int   failCount;

  logic [31:0] rfMem [32];
  logic [31:0] expRs1;
  logic [31:0] expRs2;

  operand_fetch_if #(.XLEN(32)) ofIf ();

  operand_fetch #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ofIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 reads back garbage so the forced-zero path is exercised.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= 32'hDEAD0000 | 32'(i);
    end else if (ofIf.wb_write) begin
      if (ofIf.wb_writenum == 5'd0) begin
        for (int i = 0; i < 32; i++) rfMem[i] <= 32'h0;
      end else begin
        rfMem[ofIf.wb_writenum] <= ofIf.wb_data;
      end
    end
  end

  always_comb ofIf.rf_data_out = rfMem[ofIf.rf_readnum];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2);
    ofIf.req_valid = valid;
    ofIf.req_rs1   = rs1;
    ofIf.req_rs2   = rs2;
  endtask

  task automatic writeBack(input logic [4:0] num, input logic [31:0] data);
    ofIf.wb_write    = 1'b1;
    ofIf.wb_writenum = num;
    ofIf.wb_data     = data;
    step();
    ofIf.wb_write    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectorCount      = 0;
    failCount        = 0;
    rst_n            = 1'b0;
    ofIf.rsp_ready   = 1'b0;
    ofIf.wb_write    = 1'b0;
    ofIf.wb_writenum = 5'd0;
    ofIf.wb_data     = 32'h0;
    applyStimulus(1'b0, 5'd0, 5'd0);
    step();
    step();

    checkOutput("reset_req_ready", 32'(ofIf.req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(ofIf.rsp_valid), 32'd0);
    checkOutput("reset_readnum", 32'(ofIf.rf_readnum), 32'd0);
    checkOutput("reset_rs1_val", ofIf.rsp_rs1_val, 32'h0);
    checkOutput("reset_rs2_val", ofIf.rsp_rs2_val, 32'h0);
    rst_n = 1'b1;
    step();

    // Preload through the write port while idle; the sequencer ignores it here.
    writeBack(5'd5, 32'h11);
    writeBack(5'd6, 32'h22);
    writeBack(5'd7, 32'hABCD);

    $display("[TB] basic read (5,6)");
    applyStimulus(1'b1, 5'd5, 5'd6);
    checkOutput("basic_req_ready_idle", 32'(ofIf.req_ready), 32'd1);
    step();
    applyStimulus(1'b0, 5'd31, 5'd31);
    checkOutput("basic_readnum_rs1", 32'(ofIf.rf_readnum), 32'd5);
    checkOutput("basic_req_ready_busy", 32'(ofIf.req_ready), 32'd0);
    checkOutput("basic_rsp_valid_r1", 32'(ofIf.rsp_valid), 32'd0);
    step();
    checkOutput("basic_readnum_rs2", 32'(ofIf.rf_readnum), 32'd6);
    checkOutput("basic_rsp_valid_r2", 32'(ofIf.rsp_valid), 32'd0);
    checkOutput("basic_rs1_captured", ofIf.rsp_rs1_val, 32'h11);
    step();
    checkOutput("basic_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("basic_readnum_resp", 32'(ofIf.rf_readnum), 32'd0);
    checkOutput("basic_rs1_val", ofIf.rsp_rs1_val, 32'h11);
    checkOutput("basic_rs2_val", ofIf.rsp_rs2_val, 32'h22);

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
      checkOutput("bp_req_ready", 32'(ofIf.req_ready), 32'd0);
      checkOutput("bp_rs1_val", ofIf.rsp_rs1_val, 32'h11);
      checkOutput("bp_rs2_val", ofIf.rsp_rs2_val, 32'h22);
    end
    ofIf.rsp_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", 32'(ofIf.rsp_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(ofIf.req_ready), 32'd1);

    $display("[TB] x0 operands with rsp_ready held high");
    applyStimulus(1'b1, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd9, 5'd9);
    checkOutput("x0_readnum", 32'(ofIf.rf_readnum), 32'd0);
    step();
    checkOutput("x0_rsp_valid_r2", 32'(ofIf.rsp_valid), 32'd0);
    step();
    checkOutput("x0_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("x0_rs1_val", ofIf.rsp_rs1_val, 32'h0);
    checkOutput("x0_rs2_val", ofIf.rsp_rs2_val, 32'h0);
    step();
    checkOutput("x0_done_valid", 32'(ofIf.rsp_valid), 32'd0);
    ofIf.rsp_ready = 1'b0;

    $display("[TB] same index (7,7)");
    applyStimulus(1'b1, 5'd7, 5'd7);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0);
    step();
    step();
    checkOutput("same_rs1_val", ofIf.rsp_rs1_val, 32'hABCD);
    checkOutput("same_rs2_val", ofIf.rsp_rs2_val, 32'hABCD);
    ofIf.rsp_ready = 1'b1;
    step();
    ofIf.rsp_ready = 1'b0;

    $display("[TB] write-back during READ2 and RESP, then x0 clear");
    expRs1 = BypassOn ? 32'h77 : 32'h11;
    expRs2 = BypassOn ? 32'h99 : 32'h22;
    applyStimulus(1'b1, 5'd5, 5'd6);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0);
    step();
    writeBack(5'd6, 32'h99);
    checkOutput("wb_r2_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("wb_r2_rs1_val", ofIf.rsp_rs1_val, 32'h11);
    checkOutput("wb_r2_rs2_val", ofIf.rsp_rs2_val, expRs2);
    writeBack(5'd5, 32'h77);
    checkOutput("wb_resp_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("wb_resp_rs1_val", ofIf.rsp_rs1_val, expRs1);
    checkOutput("wb_resp_rs2_val", ofIf.rsp_rs2_val, expRs2);
    writeBack(5'd0, 32'h1234);
    checkOutput("clear_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("clear_rs1_val", ofIf.rsp_rs1_val, 32'h0);
    checkOutput("clear_rs2_val", ofIf.rsp_rs2_val, 32'h0);
    ofIf.rsp_ready = 1'b1;
    step();
    checkOutput("clear_done_ready", 32'(ofIf.req_ready), 32'd1);
    ofIf.rsp_ready = 1'b0;

    $display("[TB] reset mid-operation");
    writeBack(5'd5, 32'h55);
    writeBack(5'd6, 32'h66);
    applyStimulus(1'b1, 5'd5, 5'd6);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0);
    checkOutput("rst_readnum_r1", 32'(ofIf.rf_readnum), 32'd5);
    step();
    checkOutput("rst_rs1_captured", ofIf.rsp_rs1_val, 32'h55);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_req_ready", 32'(ofIf.req_ready), 32'd1);
    checkOutput("rst_async_readnum", 32'(ofIf.rf_readnum), 32'd0);
    checkOutput("rst_async_rs1_val", ofIf.rsp_rs1_val, 32'h0);
    step();
    checkOutput("rst_req_ready", 32'(ofIf.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(ofIf.rsp_valid), 32'd0);
    checkOutput("rst_rs1_val", ofIf.rsp_rs1_val, 32'h0);
    checkOutput("rst_rs2_val", ofIf.rsp_rs2_val, 32'h0);
    rst_n = 1'b1;
    step();

    $display("[TB] request after reset");
    ofIf.rsp_ready = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd6);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0);
    step();
    step();
    checkOutput("post_rsp_valid", 32'(ofIf.rsp_valid), 32'd1);
    checkOutput("post_rs1_val", ofIf.rsp_rs1_val, 32'hDEAD0005);
    checkOutput("post_rs2_val", ofIf.rsp_rs2_val, 32'hDEAD0006);
    step();
    checkOutput("post_idle_ready", 32'(ofIf.req_ready), 32'd1);
    ofIf.rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
